// File: rtl/mem_pkg.sv
// Shared definitions for the data-RAM access unit.
//   - RV32I load/store funct3 encodings
//   - Controller state enumeration
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;  // LB / SB
    localparam logic [2:0] F3_H  = 3'd1;  // LH / SH
    localparam logic [2:0] F3_W  = 3'd2;  // LW / SW
    localparam logic [2:0] F3_BU = 3'd4;  // LBU
    localparam logic [2:0] F3_HU = 3'd5;  // LHU

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        WRITE,
        RESP
    } mau_state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and RAM bus bundle for mem_access_unit.
//   req_*  : one load/store request from the datapath (valid/ready)
//   resp_* : one-cycle completion pulse with load data and error flag
//   mem_*  : word-wide RAM port (MemWrite, A, WD, RD)
// slave  : the access unit's view; master : the datapath/RAM side.
interface mem_access_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
    );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane alignment for sub-word accesses (purely combinational).
//   rdata_i     : word read from RAM
//   wdata_i     : store data (low byte/half used for SB/SH)
//   addr_lo_i   : byte offset within the word
//   funct3_i    : RV32I load/store funct3
//   load_data_o : extracted and sign/zero-extended load result
//   merged_o    : rdata_i with the store lane replaced by wdata_i
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data_o = {24'b0, byte_sel};
            F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data_o = {16'b0, half_sel};
            default: load_data_o = rdata_i;
        endcase

        merged_o = rdata_i;
        case (funct3_i[1:0])
            2'd0:    merged_o[{addr_lo_i, 3'b000} +: 8]   = wdata_i[7:0];
            2'd1:    merged_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default: merged_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Requester-side controller for a word-wide data RAM with 1-cycle registered
// read and no byte enables. Serves one RV32I load/store at a time; SB/SH are
// done as read-modify-write.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/response handshake and RAM port (slave modport)
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 12,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_access_unit_if.slave  bus
);

    mau_state_t            state_q, state_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [31:0]           mem_a_q, mem_a_d;
    logic [DATA_WIDTH-1:0] mem_wd_q, mem_wd_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;

    logic                  req_err;
    logic                  misaligned;
    logic [31:0]           load_data;
    logic [31:0]           merged;

    // Address bits above the RAM size are dropped so accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:ADDRESS_WIDTH+2];

    mem_lane_align u_lane_align (
        .rdata_i     (bus.mem_rd),
        .wdata_i     (wdata_q),
        .addr_lo_i   (addr_lo_q),
        .funct3_i    (funct3_q),
        .load_data_o (load_data),
        .merged_o    (merged)
    );

    always_comb begin
        misaligned = 1'b0;
        case (bus.req_funct3[1:0])
            2'd1:    misaligned = bus.req_addr[0];
            2'd2:    misaligned = (bus.req_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        if (bus.req_we) begin
            req_err = (bus.req_funct3 > F3_W) || misaligned;
        end else begin
            req_err = (bus.req_funct3 inside {3'd3, 3'd6, 3'd7}) || misaligned;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_lo_d    = addr_lo_q;
        funct3_d     = funct3_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        mem_a_d      = mem_a_q;
        mem_wd_d     = mem_wd_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_lo_d = bus.req_addr[1:0];
                    funct3_d  = bus.req_funct3;
                    wdata_d   = bus.req_wdata;
                    we_d      = bus.req_we;
                    mem_a_d   = 32'(bus.req_addr[ADDRESS_WIDTH+1:2]);
                    if (req_err) begin
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                        state_d      = RESP;
                    end else if (bus.req_we && bus.req_funct3 == F3_W) begin
                        mem_wd_d = bus.req_wdata;
                        state_d  = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                if (we_q) begin
                    mem_wd_d = merged;
                    state_d  = WRITE;
                end else begin
                    resp_rdata_d = load_data;
                    resp_err_d   = 1'b0;
                    state_d      = RESP;
                end
            end
            WRITE: begin
                resp_rdata_d = '0;
                resp_err_d   = 1'b0;
                state_d      = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_lo_q    <= '0;
            funct3_q     <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            mem_a_q      <= '0;
            mem_wd_q     <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_lo_q    <= addr_lo_d;
            funct3_q     <= funct3_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            mem_a_q      <= mem_a_d;
            mem_wd_q     <= mem_wd_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.mem_we     = (state_q == WRITE);
    assign bus.mem_a      = mem_a_q;
    assign bus.mem_wd     = mem_wd_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: bench-side RAM, a byte-level
// reference model, directed test-plan cases with literal expectations,
// back-to-back and randomized traffic, and a mid-operation reset.
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if bus ();

    mem_access_unit #(
        .ADDRESS_WIDTH (12),
        .DATA_WIDTH    (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Bench RAM: registered read, RD held during writes.
    logic [31:0] ram [4096];
    logic [31:0] ram_rd;
    logic [31:0] shadow [4096];
    bit          shadow_ready = 1'b0;
    bit          ram_loaded = 1'b0;
    assign bus.mem_rd = ram_rd;

    always @(posedge clk) begin
        if (shadow_ready && !ram_loaded) begin
            for (int i = 0; i < 4096; i++) ram[i] <= shadow[i];
            ram_loaded <= 1'b1;
        end else if (bus.mem_we) begin
            ram[bus.mem_a[11:0]] <= bus.mem_wd;
        end else begin
            ram_rd <= ram[bus.mem_a[11:0]];
        end
    end

    // Reference model: byte-addressed view of the word RAM.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output bit err, output bit wr,
                         output logic [31:0] rd, output logic [31:0] wnew, output int idx);
        logic [31:0] word, mask, v;
        int          sh;
        bit          illegal, mis;
        idx  = int'((addr / 4) % 4096);
        word = shadow[idx];
        sh   = int'(addr % 4) * 8;
        illegal = we ? (f3 > 2) : (f3 == 3 || f3 >= 6);
        mis  = ((f3 % 4) == 1 && (addr % 2) != 0) || ((f3 % 4) == 2 && (addr % 4) != 0);
        mask = ((f3 % 4) == 0) ? 32'hFF : 32'hFFFF;
        err  = illegal || mis;
        wr   = 1'b0;
        rd   = 32'h0;
        wnew = word;
        if (err) begin
            lat = 0;
        end else if (we) begin
            wr = 1'b1;
            if (f3 == 2) begin
                lat  = 1;
                wnew = wd;
            end else begin
                lat  = 3;
                wnew = (word & ~(mask << sh)) | ((wd & mask) << sh);
            end
        end else begin
            lat = 2;
            if ((f3 % 4) == 2) begin
                rd = word;
            end else begin
                v = (word >> sh) & mask;
                if (f3 < 4 && v > (mask >> 1)) v = v | ~mask;
                rd = v;
            end
        end
    endtask

    // Literal expectations supplied by the driver for directed cases.
    bit          lit_en = 1'b0;
    logic [31:0] lit_rd = '0;
    logic        lit_err = 1'b0;
    int          lit_lat = 0;
    int          lit_wek = -1;
    bit          b2b_mode = 1'b0;

    // Compare process state.
    int          t = 0;
    int          k;
    bit          busy = 1'b0;
    int          t_acc, m_lat, m_idx;
    bit          m_err, m_wr;
    logic [31:0] m_rd, m_a, m_wd;
    bit          c_lit;
    logic [31:0] c_lit_rd;
    logic        c_lit_err;
    int          c_lit_lat, c_lit_wek;
    logic [31:0] held_rd = '0;
    logic        held_err = 1'b0;
    logic [31:0] last_a = '0;
    bit          prev_b2b = 1'b0;
    int          prev_acc = 0, prev_lat = 0;

    always @(negedge clk) begin
        t++;
        if (!shadow_ready) begin
            for (int i = 0; i < 4096; i++) shadow[i] = $urandom;
            shadow[64] = 32'h8899AABB;
            shadow_ready = 1'b1;
        end
        if (!rst_n) begin
            busy = 1'b0; held_rd = '0; held_err = 1'b0; last_a = '0; prev_b2b = 1'b0;
            chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
            chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
            chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
            chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
            chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
            chk("rst_mem_a", bus.mem_a, 32'd0);
            chk("rst_mem_wd", bus.mem_wd, 32'd0);
        end else if (busy) begin
            k = t - t_acc - 1;
            chk("busy_req_ready", 32'(bus.req_ready), 32'd0);
            chk("resp_valid", 32'(bus.resp_valid), 32'(k == m_lat));
            chk("mem_we", 32'(bus.mem_we), 32'(m_wr && k == m_lat - 1));
            chk("mem_a", bus.mem_a, m_a);
            if (m_wr && k == m_lat - 1) chk("mem_wd", bus.mem_wd, m_wd);
            if (c_lit && bus.resp_valid) chk("lit_latency", k, c_lit_lat);
            if (c_lit && bus.mem_we) chk("lit_we_cycle", k, c_lit_wek);
            if (k >= m_lat) begin
                chk("resp_rdata", bus.resp_rdata, m_rd);
                chk("resp_err", 32'(bus.resp_err), 32'(m_err));
                if (c_lit) begin
                    chk("lit_rdata", bus.resp_rdata, c_lit_rd);
                    chk("lit_err", 32'(bus.resp_err), 32'(c_lit_err));
                end
                held_rd = m_rd; held_err = m_err;
                if (m_wr) shadow[m_idx] = m_wd;
                busy = 1'b0;
            end
        end else begin
            chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
            chk("idle_resp_valid", 32'(bus.resp_valid), 32'd0);
            chk("idle_mem_we", 32'(bus.mem_we), 32'd0);
            chk("hold_rdata", bus.resp_rdata, held_rd);
            chk("hold_err", 32'(bus.resp_err), 32'(held_err));
            chk("hold_mem_a", bus.mem_a, last_a);
            if (bus.req_valid) begin
                model(bus.req_we, bus.req_funct3, bus.req_addr, bus.req_wdata,
                      m_lat, m_err, m_wr, m_rd, m_wd, m_idx);
                m_a = 32'(m_idx);
                last_a = m_a;
                c_lit = lit_en; c_lit_rd = lit_rd; c_lit_err = lit_err;
                c_lit_lat = lit_lat; c_lit_wek = lit_wek;
                if (b2b_mode && prev_b2b) chk("b2b_gap", t - prev_acc, prev_lat + 2);
                prev_b2b = b2b_mode; prev_acc = t; prev_lat = m_lat;
                t_acc = t;
                busy = 1'b1;
            end
        end
    end

    task automatic note_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    task automatic wait_ready();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_ready && n < 50);
        if (!bus.req_ready) note_fail("ready_timeout");
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 50);
        if (busy) note_fail("resp_timeout");
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit le, input logic [31:0] lrd,
                         input logic lerr, input int llat, input int lwek);
        @(posedge clk);
        #1;
        lit_en = le; lit_rd = lrd; lit_err = lerr; lit_lat = llat; lit_wek = lwek;
        bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lit_en = 1'b0;
        wait_idle();
    endtask

    task automatic rand_req();
        logic [2:0] legal [5];
        legal = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        bus.req_we     = 1'($urandom % 2);
        bus.req_funct3 = ($urandom % 6 == 0) ? 3'($urandom) : legal[$urandom % 5];
        bus.req_addr   = ($urandom % 5 == 0) ? $urandom : 32'($urandom_range(0, 127));
        bus.req_wdata  = $urandom;
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
        bus.req_addr = '0; bus.req_wdata = '0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;

        // Loads from word 0x40 = 0x8899AABB.
        issue(1'b0, 3'd0, 32'h101, 32'h0, 1'b1, 32'hFFFFFFAA, 1'b0, 2, -1);
        issue(1'b0, 3'd4, 32'h103, 32'h0, 1'b1, 32'h00000088, 1'b0, 2, -1);
        issue(1'b0, 3'd5, 32'h100, 32'h0, 1'b1, 32'h0000AABB, 1'b0, 2, -1);
        // SH read-modify-write, then read back.
        issue(1'b1, 3'd1, 32'h102, 32'h5A5A1234, 1'b1, 32'h0, 1'b0, 3, 2);
        issue(1'b0, 3'd2, 32'h100, 32'h0, 1'b1, 32'h1234AABB, 1'b0, 2, -1);
        // SW, SB into the same word, read back.
        issue(1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 1, 0);
        issue(1'b1, 3'd0, 32'h105, 32'h00000011, 1'b1, 32'h0, 1'b0, 3, 2);
        issue(1'b0, 3'd2, 32'h104, 32'h0, 1'b1, 32'hDEAD11EF, 1'b0, 2, -1);
        // Errors.
        issue(1'b0, 3'd2, 32'h102, 32'h0, 1'b1, 32'h0, 1'b1, 0, -1);
        issue(1'b0, 3'd1, 32'h101, 32'h0, 1'b1, 32'h0, 1'b1, 0, -1);
        issue(1'b0, 3'd3, 32'h100, 32'h0, 1'b1, 32'h0, 1'b1, 0, -1);
        issue(1'b1, 3'd6, 32'h100, 32'h0, 1'b1, 32'h0, 1'b1, 0, -1);
        // Address wrap.
        issue(1'b0, 3'd2, 32'h4000, 32'h0, 1'b0, 32'h0, 1'b0, 0, -1);
        chk("wrap_mem_a", bus.mem_a, 32'h0);

        // SB 0x100 abandoned by reset during CAPTURE.
        @(posedge clk);
        #1;
        bus.req_we = 1'b1; bus.req_funct3 = 3'd0; bus.req_addr = 32'h100;
        bus.req_wdata = 32'h77; bus.req_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("arst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("arst_mem_wd", bus.mem_wd, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("arst_ram_word", ram[64], 32'h1234AABB);
        issue(1'b0, 3'd2, 32'h100, 32'h0, 1'b1, 32'h1234AABB, 1'b0, 2, -1);

        // Back-to-back with req_valid held high.
        @(posedge clk);
        #1;
        b2b_mode = 1'b1;
        rand_req();
        bus.req_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wait_ready();
            @(posedge clk);
            #1;
            if (i < 39) rand_req();
            else bus.req_valid = 1'b0;
        end
        wait_idle();
        b2b_mode = 1'b0;

        // Randomized traffic with idle gaps.
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom % 3) @(posedge clk);
            rand_req();
            issue(bus.req_we, bus.req_funct3, bus.req_addr, bus.req_wdata,
                  1'b0, 32'h0, 1'b0, 0, -1);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
